reg_delay_set: RTL and testbench

Parameterized register primitive set for pipelined datapaths. It bundles three independent register paths sharing one clock and one reset:
- a single-cycle delay (d1 behaviour);
- an N-cycle delay line (dn behaviour);
- a clearable, enabled holding register (r behaviour, used for counters and accumulators).

Pipelines such as the FAST corner mask use these paths to retime data, data-valid and thresholds, and to build row/column counters.

---
 rtl/reg_delay_set.sv | 56 +++++
 tb/tb_reg_delay_set.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/reg_delay_set.sv
// rtl/reg_delay_set.sv - single delay, N-stage delay line and clearable enabled register
// Three independent register paths sharing one clock and one reset.
module reg_delay_set #(
  parameter int unsigned     W  = 1,
  parameter int unsigned     N  = 4,
  parameter logic [W-1:0]    RV = '0
) (
  input  logic         c,
  input  logic         rst,
  input  logic [W-1:0] d1_d,
  output logic [W-1:0] d1_q,
  input  logic [W-1:0] dn_d,
  output logic [W-1:0] dn_q,
  input  logic         r_clr,
  input  logic         r_en,
  input  logic [W-1:0] r_d,
  output logic [W-1:0] r_q
);

  logic [W-1:0] stage [N];

  always_ff @(posedge c or posedge rst) begin
    if (rst) begin
      d1_q <= '0;
    end else begin
      d1_q <= d1_d;
    end
  end

  // A reset flushes every stage so no pre-reset data leaks out afterwards.
  always_ff @(posedge c or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(N); k++) begin
        stage[k] <= '0;
      end
    end else begin
      stage[0] <= dn_d;
      for (int k = 1; k < int'(N); k++) begin
        stage[k] <= stage[k-1];
      end
    end
  end

  assign dn_q = stage[N-1];

  always_ff @(posedge c or posedge rst) begin
    if (rst) begin
      r_q <= RV;
    end else if (r_clr) begin
      r_q <= RV;
    end else if (r_en) begin
      r_q <= r_d;
    end
  end

endmodule

// File: tb/tb_reg_delay_set.sv
// tb/tb_reg_delay_set.sv - directed self-checking bench for reg_delay_set
module tb_reg_delay_set;

  logic c = 1'b0;
  logic rst = 1'b0;
  always #5 c = ~c;

  int n_cmp = 0;
  int n_err = 0;

  // u8: W=8, N=4, RV=0
  logic [7:0] d1_d_8 = '0, dn_d_8 = '0, r_d_8 = '0;
  logic [7:0] d1_q_8, dn_q_8, r_q_8;
  logic       r_clr_8 = 1'b0, r_en_8 = 1'b0;

  // u144: W=144, N=1
  logic [143:0] d1_d_w = '0, dn_d_w = '0, r_d_w = '0;
  logic [143:0] d1_q_w, dn_q_w, r_q_w;
  logic         r_clr_w = 1'b0, r_en_w = 1'b0;

  // u16: W=16, N=4, RV=0, wired as a counter
  logic [15:0] d1_d_16 = '0, dn_d_16 = '0, r_d_16;
  logic [15:0] d1_q_16, dn_q_16, r_q_16;
  logic        r_clr_16 = 1'b0, r_en_16 = 1'b0;
  assign r_d_16 = r_q_16 + 16'd1;

  // ur: W=8, N=2, RV=0x5A
  logic [7:0] d1_d_r = '0, dn_d_r = '0, r_d_r = '0;
  logic [7:0] d1_q_r, dn_q_r, r_q_r;
  logic       r_clr_r = 1'b0, r_en_r = 1'b0;

  reg_delay_set #(.W(8), .N(4), .RV(8'h00)) u8 (
    .c(c), .rst(rst), .d1_d(d1_d_8), .d1_q(d1_q_8), .dn_d(dn_d_8), .dn_q(dn_q_8),
    .r_clr(r_clr_8), .r_en(r_en_8), .r_d(r_d_8), .r_q(r_q_8));

  reg_delay_set #(.W(144), .N(1), .RV(144'h0)) u144 (
    .c(c), .rst(rst), .d1_d(d1_d_w), .d1_q(d1_q_w), .dn_d(dn_d_w), .dn_q(dn_q_w),
    .r_clr(r_clr_w), .r_en(r_en_w), .r_d(r_d_w), .r_q(r_q_w));

  reg_delay_set #(.W(16), .N(4), .RV(16'h0000)) u16 (
    .c(c), .rst(rst), .d1_d(d1_d_16), .d1_q(d1_q_16), .dn_d(dn_d_16), .dn_q(dn_q_16),
    .r_clr(r_clr_16), .r_en(r_en_16), .r_d(r_d_16), .r_q(r_q_16));

  reg_delay_set #(.W(8), .N(2), .RV(8'h5A)) ur (
    .c(c), .rst(rst), .d1_d(d1_d_r), .d1_q(d1_q_r), .dn_d(dn_d_r), .dn_q(dn_q_r),
    .r_clr(r_clr_r), .r_en(r_en_r), .r_d(r_d_r), .r_q(r_q_r));

  task automatic tick();
    @(posedge c);
    #1;
  endtask

  task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [143:0] pat;
    logic [7:0]   e8;

    // Fill the paths with nonzero data, then reset between edges.
    d1_d_8 = 8'hAA; dn_d_8 = 8'hBB; r_d_8 = 8'hCC; r_en_8 = 1'b1;
    r_d_r = 8'h11; r_en_r = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("pre_rst_d1", d1_q_8, 8'hAA);
    check("pre_rst_dn", dn_q_8, 8'hBB);
    check("pre_rst_r", r_q_8, 8'hCC);
    rst = 1'b1;
    #1;
    check("async_rst_d1", d1_q_8, 8'h00);
    check("async_rst_dn", dn_q_8, 8'h00);
    check("async_rst_r", r_q_8, 8'h00);
    check("async_rst_rv", r_q_r, 8'h5A);
    tick();
    check("rst_hold_d1", d1_q_8, 8'h00);
    check("rst_hold_rv", r_q_r, 8'h5A);
    r_en_8 = 1'b0; r_en_r = 1'b0; d1_d_8 = '0; dn_d_8 = '0;
    rst = 1'b0;

    // d1 latency
    d1_d_8 = 8'h41; tick(); check("d1_41", d1_q_8, 8'h41);
    d1_d_8 = 8'h42; tick(); check("d1_42", d1_q_8, 8'h42);
    d1_d_8 = 8'h43; tick(); check("d1_43", d1_q_8, 8'h43);

    // dn pulse, N=4
    dn_d_8 = 8'hFF; tick(); dn_d_8 = 8'h00;
    check("dn_pulse_1", dn_q_8, 8'h00);
    for (int i = 2; i <= 6; i++) begin
      tick();
      check($sformatf("dn_pulse_%0d", i), dn_q_8, (i == 4) ? 8'hFF : 8'h00);
    end

    // Walking ones through W=144, N=1
    for (int i = 0; i < 144; i++) begin
      pat = 144'h1 << i;
      dn_d_w = pat; d1_d_w = ~pat;
      tick();
      check($sformatf("w144_dn_%0d", i), dn_q_w, pat);
      check($sformatf("w144_d1_%0d", i), d1_q_w, ~pat);
    end

    // Enabled counter
    check("cnt_start", r_q_16, 16'd0);
    r_en_16 = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("cnt_%0d", i), r_q_16, 16'(i));
    end
    r_en_16 = 1'b0;
    tick(); tick();
    check("cnt_hold", r_q_16, 16'd5);
    r_clr_16 = 1'b1; r_en_16 = 1'b1;
    tick();
    check("clr_priority", r_q_16, 16'd0);
    r_clr_16 = 1'b0;
    tick();
    check("after_clr_en", r_q_16, 16'd1);
    r_en_16 = 1'b0;
    tick();
    check("after_clr_hold", r_q_16, 16'd1);

    // Nonzero RV and N=2
    r_d_r = 8'h33; r_en_r = 1'b1;
    tick(); check("rv_load", r_q_r, 8'h33);
    r_clr_r = 1'b1;
    tick(); check("rv_clear", r_q_r, 8'h5A);
    r_clr_r = 1'b0; r_en_r = 1'b0; r_d_r = 8'h77;
    tick(); check("rv_hold", r_q_r, 8'h5A);
    dn_d_r = 8'hC3; tick(); dn_d_r = 8'h00;
    check("n2_dn_1", dn_q_r, 8'h00);
    tick(); check("n2_dn_2", dn_q_r, 8'hC3);
    tick(); check("n2_dn_3", dn_q_r, 8'h00);

    // Ramp through N=4 with a mid-stream reset
    for (int i = 0; i < 8; i++) begin
      dn_d_8 = 8'h20 + 8'(i);
      tick();
      e8 = (i >= 3) ? 8'h20 + 8'(i - 3) : 8'h00;
      check($sformatf("ramp_pre_%0d", i), dn_q_8, e8);
    end
    rst = 1'b1;
    #1;
    check("mid_rst_dn", dn_q_8, 8'h00);
    tick();
    check("mid_rst_dn_edge", dn_q_8, 8'h00);
    rst = 1'b0;
    check("mid_rel_dn", dn_q_8, 8'h00);
    for (int j = 0; j < 8; j++) begin
      dn_d_8 = 8'h40 + 8'(j);
      tick();
      e8 = (j >= 3) ? 8'h40 + 8'(j - 3) : 8'h00;
      check($sformatf("ramp_post_%0d", j), dn_q_8, e8);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
